ram_block_copier: RTL and testbench
===================================

# ram_block_copier

Upstream master for the 8-bit-address, 32-bit-data banked RAM: copies a block of `len` words from `src_addr` to `dst_addr` by sequencing read and write cycles on the RAM's address/write/data port. It sits directly in front of the memory top level, drives `Address`/`Write`/`In`, and consumes `Dout`. Control is a start/busy/done handshake for the owning controller.

## Interface
- `RD_LAT`, 1: clocks from read address presented (`mem_write`=0) to valid `mem_rdata`; legal 1..4.
- `clk` in 1: rising-edge clock shared with the RAM.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request; sampled only in IDLE.
- `src_addr` in 8: first source word address, latched on accepted start.
- `dst_addr` in 8: first destination word address, latched on accepted start.
- `len` in 9: word count, 0..256, latched on accepted start.
- `busy` out 1: high from cycle after accepted start until done.
- `done` out 1: one-cycle completion pulse.
- `mem_addr` out 8: to RAM `Address`; bits [7:6] are the bank select.
- `mem_write` out 1: to RAM `Write`.
- `mem_wdata` out 32: to RAM `In`.
- `mem_rdata` in 32: from RAM `Dout`.
- `checksum` out 32: see Configuration.

## Operation
- States: IDLE, RD, WAIT, WR, FIN.
- IDLE: `start`=1 latches `src`, `dst`, `len` into internal pointers/counter. If `len`=0 go to FIN, else go to RD.
- RD (1 cycle): `mem_addr`=src pointer, `mem_write`=0. Go to WAIT.
- WAIT (`RD_LAT` cycles): `mem_write`=0, address held. On the last WAIT cycle, `mem_rdata` is registered into a data buffer. Go to WR.
- WR (1 cycle):
  - `mem_addr`=dst pointer, `mem_wdata`=buffer, `mem_write`=1.
  - Both pointers increment.
  - Counter decrements; if it reaches 0 go to FIN, else go to RD.
- FIN (1 cycle): `done`=1, `busy`=0. Go to IDLE.
- Pointers are 8-bit and wrap 255→0, crossing banks transparently. A 256-word copy therefore touches every address once.
- Copy order is strictly ascending. Overlapping regions with dst > src propagate already-overwritten data; this is the defined behaviour, with no overlap detection.
- `start` while not IDLE is ignored; it is not queued.
- Outside WR, `mem_write`=0 always and `mem_wdata` holds its last value.

## Timing
- All outputs are registered.
- Reset values: `busy`=0, `done`=0, `mem_addr`=0, `mem_write`=0, `mem_wdata`=0, `checksum`=0, state IDLE.
- `rst` mid-copy aborts immediately. No further writes occur; words already written stay written. No `done` is issued.
- Start accepted at edge k gives first RD at cycle k+1.
- Each word takes 2+`RD_LAT` cycles (3 at default).
- Latency from start to `done` is 1 + len·(2+`RD_LAT`) + 1 cycles. For `len`=0 it is 2 cycles.
- `start` held high through FIN starts a new copy in the cycle after FIN (IDLE sample).

## Configuration
- `RAM_COPY_CHECKSUM_EN` defined:
  - `checksum` accumulates the modulo-2^32 sum of every word written.
  - It clears to 0 on each accepted start.
  - It is final and stable from the `done` cycle until the next accepted start.
- Not defined: `checksum` is constant 0 and no adder is built.

## Test plan
- **Basic copy:** preload addr 0x43=12, 0x44=15; start src=0x43, dst=0x83, len=2.
  - Expect writes 0x83←12 and 0x84←15 in order.
  - Expect `done` exactly 8 cycles after start.
  - With the macro defined, expect `checksum`=27.
- **Zero length:** start with len=0.
  - Expect no `mem_write` pulse.
  - Expect `done` 2 cycles after start and `busy` high for 1 cycle.
- **Wrap:** src=0xFF, dst=0x00, len=2, with 0xFF=20, 0x00=14.
  - Expect writes 0x00←20 then 0x01←20 (overlap propagation).
  - Expect the second read at 0x00.
- **Start while busy:** pulse `start` during WAIT with different args.
  - Expect it ignored: only the original copy is performed and only one `done`.
- **Reset mid-op:** start len=4; assert `rst` during the third RD.
  - Expect all outputs to reset values asynchronously.
  - Expect exactly 2 destination words written and no `done`.
- **Latency parameter:** `RD_LAT`=3, len=1.
  - Expect the write 4 cycles after RD.
  - Expect `done` at start+7.

Source files
------------

// File: rtl/ram_block_copier.sv
// rtl/ram_block_copier.sv - block copy master for the 8-bit-address, 32-bit-data banked RAM
// Optional feature macro: RAM_COPY_CHECKSUM_EN (adds a running sum of written words on o_checksum).
// The FSM state leads the RAM bus by one cycle. Every output is a register
// loaded from the current state, so the bus shows RD/WAIT/WR one cycle after
// the state register enters them. In the state WR the bus is still in its last
// WAIT cycle, so i_mem_rdata is valid and is captured straight into
// o_mem_wdata. That register acts as the read buffer.
module ram_block_copier #(
  parameter int RD_LAT = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [7:0]  i_src_addr,
  input  logic [7:0]  i_dst_addr,
  input  logic [8:0]  i_len,
  output logic        o_busy,
  output logic        o_done,
  output logic [7:0]  o_mem_addr,
  output logic        o_mem_write,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  output logic [31:0] o_checksum
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_WR   = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

  state_t     r_state;
  state_t     w_next;
  logic       w_accept;
  logic [7:0] r_src;
  logic [7:0] r_dst;
  logic [8:0] r_cnt;
  logic [1:0] r_wait;

  // Next-state decode; a start is only accepted from IDLE, never queued
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_accept = 1'b1;
          w_next   = (i_len == 9'd0) ? S_FIN : S_RD;
        end
      end
      S_RD:   w_next = S_WAIT;
      S_WAIT: begin
        if (r_wait == 2'd0) begin
          w_next = S_WR;
        end
      end
      S_WR:   w_next = (r_cnt == 9'd1) ? S_FIN : S_RD;
      S_FIN:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Pointers, word counter and read-latency counter; pointers wrap 255->0
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_src  <= 8'd0;
      r_dst  <= 8'd0;
      r_cnt  <= 9'd0;
      r_wait <= 2'd0;
    end else begin
      if (w_accept) begin
        r_src <= i_src_addr;
        r_dst <= i_dst_addr;
        r_cnt <= i_len;
      end
      if (r_state == S_RD) begin
        r_wait <= WAIT_LAST;
      end else if ((r_state == S_WAIT) && (r_wait != 2'd0)) begin
        r_wait <= r_wait - 2'd1;
      end
      if (r_state == S_WR) begin
        r_src <= r_src + 8'd1;
        r_dst <= r_dst + 8'd1;
        r_cnt <= r_cnt - 9'd1;
      end
    end
  end

  // Registered bus and handshake outputs; address and write data hold outside RD/WR
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_mem_addr  <= 8'd0;
      o_mem_write <= 1'b0;
      o_mem_wdata <= 32'd0;
    end else begin
      o_busy      <= (w_next != S_IDLE);
      o_done      <= (r_state == S_FIN);
      o_mem_write <= (r_state == S_WR);
      if (r_state == S_RD) begin
        o_mem_addr <= r_src;
      end else if (r_state == S_WR) begin
        o_mem_addr  <= r_dst;
        o_mem_wdata <= i_mem_rdata;
      end
    end
  end

`ifdef RAM_COPY_CHECKSUM_EN
  logic [31:0] r_checksum;

  // Running sum of written words, cleared on each accepted start
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_checksum <= 32'd0;
    end else if (w_accept) begin
      r_checksum <= 32'd0;
    end else if (r_state == S_WR) begin
      r_checksum <= r_checksum + i_mem_rdata;
    end
  end

  assign o_checksum = r_checksum;
`else
  assign o_checksum = 32'd0;
`endif

endmodule

// File: tb/tb_ram_block_copier.sv
// tb/tb_ram_block_copier.sv - directed self-checking bench for ram_block_copier
`timescale 1ns/1ps
module tb_ram_block_copier;

`ifdef RAM_COPY_CHECKSUM_EN
  localparam logic [31:0] CSUM_BASIC = 32'd27;
`else
  localparam logic [31:0] CSUM_BASIC = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start, b_start;
  logic [7:0]  src, dst;
  logic [8:0]  len;

  logic        busy, done, mwrite;
  logic [7:0]  maddr;
  logic [31:0] mwdata, rdata_a, csum;

  logic        b_busy, b_done, b_mwrite;
  logic [7:0]  b_maddr;
  logic [31:0] b_mwdata, rdata_b, b_csum;

  logic        pre_we, pre_sel;
  logic [7:0]  pre_a;
  logic [31:0] pre_d;

  logic [31:0] mem_a [0:255];
  logic [31:0] mem_b [0:255];
  logic [7:0]  b_ap1, b_ap2;

  int cyc = 0;
  int wr_n = 0, done_n = 0, done_cyc = 0, busy_n = 0;
  int wr_addr [0:63];
  int wr_data [0:63];
  int wr_cyc  [0:63];
  int b_wr_n = 0, b_wr_addr = 0, b_wr_data = 0, b_wr_cyc = 0;
  int b_done_n = 0, b_done_cyc = 0;

  int n_chk = 0, n_err = 0;
  int s0, wb, db, bb;

  always #5 clk = ~clk;

  ram_block_copier #(.RD_LAT(1)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_src_addr(src), .i_dst_addr(dst), .i_len(len),
    .o_busy(busy), .o_done(done),
    .o_mem_addr(maddr), .o_mem_write(mwrite), .o_mem_wdata(mwdata),
    .i_mem_rdata(rdata_a), .o_checksum(csum)
  );

  ram_block_copier #(.RD_LAT(3)) u_dut_lat3 (
    .i_clk(clk), .i_rst(rst), .i_start(b_start),
    .i_src_addr(src), .i_dst_addr(dst), .i_len(len),
    .o_busy(b_busy), .o_done(b_done),
    .o_mem_addr(b_maddr), .o_mem_write(b_mwrite), .o_mem_wdata(b_mwdata),
    .i_mem_rdata(rdata_b), .o_checksum(b_csum)
  );

  // RAM with one clock of read latency
  always @(posedge clk) begin
    if (mwrite) mem_a[maddr] <= mwdata;
    else if (pre_we && !pre_sel) mem_a[pre_a] <= pre_d;
    rdata_a <= mem_a[maddr];
  end

  // RAM with three clocks of read latency
  always @(posedge clk) begin
    if (b_mwrite) mem_b[b_maddr] <= b_mwdata;
    else if (pre_we && pre_sel) mem_b[pre_a] <= pre_d;
    b_ap1   <= b_maddr;
    b_ap2   <= b_ap1;
    rdata_b <= mem_b[b_ap2];
  end

  // Bus monitor: cycle numbers are the period that just ended
  always @(posedge clk) begin
    cyc <= cyc + 1;
    busy_n <= busy_n + int'(busy);
    if (mwrite && wr_n < 64) begin
      wr_addr[wr_n] <= int'(maddr);
      wr_data[wr_n] <= int'(mwdata);
      wr_cyc[wr_n]  <= cyc;
      wr_n          <= wr_n + 1;
    end
    if (done) begin
      done_n   <= done_n + 1;
      done_cyc <= cyc;
    end
    if (b_mwrite) begin
      b_wr_n    <= b_wr_n + 1;
      b_wr_addr <= int'(b_maddr);
      b_wr_data <= int'(b_mwdata);
      b_wr_cyc  <= cyc;
    end
    if (b_done) begin
      b_done_n   <= b_done_n + 1;
      b_done_cyc <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic sel, input logic [7:0] a, input logic [31:0] d);
    pre_sel = sel; pre_a = a; pre_d = d; pre_we = 1'b1;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic do_start(input logic which, input logic [7:0] s, input logic [7:0] d,
                          input logic [8:0] l);
    src = s; dst = d; len = l;
    if (which) b_start = 1'b1; else start = 1'b1;
    s0 = cyc;
    tick();
    start = 1'b0; b_start = 1'b0;
  endtask

  task automatic wait_done(input logic which, input int base, input string tag);
    int k;
    k = 0;
    while (((which ? b_done_n : done_n) == base) && k < 80) begin
      tick();
      k++;
    end
    check(tag, 32'((which ? b_done_n : done_n) - base), 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; b_start = 1'b0;
    src = 8'd0; dst = 8'd0; len = 9'd0;
    pre_we = 1'b0; pre_sel = 1'b0; pre_a = 8'd0; pre_d = 32'd0;
    tick(); tick();
    check("rst_busy",  32'(busy),   32'd0);
    check("rst_done",  32'(done),   32'd0);
    check("rst_addr",  32'(maddr),  32'd0);
    check("rst_write", 32'(mwrite), 32'd0);
    check("rst_wdata", mwdata,      32'd0);
    check("rst_csum",  csum,        32'd0);
    rst = 1'b0;
    tick();

    // Basic copy
    preload(1'b0, 8'h43, 32'd12);
    preload(1'b0, 8'h44, 32'd15);
    wb = wr_n; db = done_n;
    do_start(1'b0, 8'h43, 8'h83, 9'd2);
    check("basic_busy_next", 32'(busy), 32'd1);
    wait_done(1'b0, db, "basic_done_seen");
    check("basic_done_lat", 32'(done_cyc - s0), 32'd8);
    check("basic_wr_count", 32'(wr_n - wb), 32'd2);
    check("basic_wr0_addr", 32'(wr_addr[wb]), 32'h83);
    check("basic_wr0_data", 32'(wr_data[wb]), 32'd12);
    check("basic_wr0_cyc",  32'(wr_cyc[wb] - s0), 32'd4);
    check("basic_wr1_addr", 32'(wr_addr[wb+1]), 32'h84);
    check("basic_wr1_data", 32'(wr_data[wb+1]), 32'd15);
    check("basic_csum", csum, CSUM_BASIC);
    check("basic_busy_after", 32'(busy), 32'd0);
    check("basic_done_pulse", 32'(done), 32'd0);

    // Zero length
    wb = wr_n; db = done_n; bb = busy_n;
    do_start(1'b0, 8'h10, 8'h20, 9'd0);
    wait_done(1'b0, db, "zero_done_seen");
    check("zero_done_lat", 32'(done_cyc - s0), 32'd2);
    check("zero_no_write", 32'(wr_n - wb), 32'd0);
    check("zero_busy_cycles", 32'(busy_n - bb), 32'd1);

    // Wrap across 0xFF with overlap propagation
    preload(1'b0, 8'hFF, 32'd20);
    preload(1'b0, 8'h00, 32'd14);
    preload(1'b0, 8'h01, 32'h55);
    wb = wr_n; db = done_n;
    do_start(1'b0, 8'hFF, 8'h00, 9'd2);
    while (cyc < s0 + 2) tick();
    check("wrap_rd1_addr", 32'(maddr), 32'hFF);
    check("wrap_rd1_write", 32'(mwrite), 32'd0);
    while (cyc < s0 + 5) tick();
    check("wrap_rd2_addr", 32'(maddr), 32'h00);
    check("wrap_rd2_write", 32'(mwrite), 32'd0);
    wait_done(1'b0, db, "wrap_done_seen");
    check("wrap_wr0_addr", 32'(wr_addr[wb]), 32'h00);
    check("wrap_wr0_data", 32'(wr_data[wb]), 32'd20);
    check("wrap_wr1_addr", 32'(wr_addr[wb+1]), 32'h01);
    check("wrap_wr1_data", 32'(wr_data[wb+1]), 32'd20);
    check("wrap_mem01", mem_a[8'h01], 32'd20);

    // Start pulsed during WAIT is ignored
    preload(1'b0, 8'h10, 32'hA);
    preload(1'b0, 8'h11, 32'hB);
    preload(1'b0, 8'h40, 32'h77);
    wb = wr_n; db = done_n;
    do_start(1'b0, 8'h10, 8'h20, 9'd2);
    while (cyc < s0 + 3) tick();
    src = 8'h30; dst = 8'h40; len = 9'd1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(1'b0, db, "ign_done_seen");
    check("ign_done_lat", 32'(done_cyc - s0), 32'd8);
    for (int i = 0; i < 12; i++) tick();
    check("ign_done_count", 32'(done_n - db), 32'd1);
    check("ign_wr_count", 32'(wr_n - wb), 32'd2);
    check("ign_wr0_addr", 32'(wr_addr[wb]), 32'h20);
    check("ign_wr1_data", 32'(wr_data[wb+1]), 32'hB);
    check("ign_mem40", mem_a[8'h40], 32'h77);

    // Reset during the third RD
    for (int i = 0; i < 4; i++) begin
      preload(1'b0, 8'(8'h50 + i), 32'(i + 1));
      preload(1'b0, 8'(8'h60 + i), 32'hEE);
    end
    wb = wr_n; db = done_n;
    do_start(1'b0, 8'h50, 8'h60, 9'd4);
    while (cyc < s0 + 8) tick();
    check("rmid_rd3_addr", 32'(maddr), 32'h52);
    #2;
    rst = 1'b1;
    #1;
    check("rmid_busy",  32'(busy),   32'd0);
    check("rmid_done",  32'(done),   32'd0);
    check("rmid_addr",  32'(maddr),  32'd0);
    check("rmid_write", 32'(mwrite), 32'd0);
    check("rmid_wdata", mwdata,      32'd0);
    check("rmid_csum",  csum,        32'd0);
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("rmid_wr_count", 32'(wr_n - wb), 32'd2);
    check("rmid_no_done", 32'(done_n - db), 32'd0);
    check("rmid_mem61", mem_a[8'h61], 32'd2);
    check("rmid_mem62", mem_a[8'h62], 32'hEE);

    // Read latency of three
    preload(1'b1, 8'h05, 32'h1234);
    db = b_done_n; wb = b_wr_n;
    do_start(1'b1, 8'h05, 8'h90, 9'd1);
    wait_done(1'b1, db, "lat3_done_seen");
    check("lat3_done_lat", 32'(b_done_cyc - s0), 32'd7);
    check("lat3_wr_count", 32'(b_wr_n - wb), 32'd1);
    check("lat3_wr_cyc", 32'(b_wr_cyc - s0), 32'd6);
    check("lat3_wr_addr", 32'(b_wr_addr), 32'h90);
    check("lat3_wr_data", 32'(b_wr_data), 32'h1234);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
